// File: rtl/booth_mult_arbiter_if.sv
// Issue/response bundle between NREQ client blocks and the shared Booth multiplier arbiter.
// Requester i occupies lane i of each packed vector.
interface booth_mult_arbiter_if #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*N-1:0]     req_a;
  logic [NREQ*N-1:0]     req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*2*N-1:0]   rsp_result;
  logic [NREQ-1:0]       rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NREQ requesters.
// A tag pipeline aligned with the multiplier latency steers each product back to its owner.
module booth_mult_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  booth_mult_arbiter_if.slave bus,
  output logic                mul_en_o,
  output logic [N-1:0]        mul_a_o,
  output logic [N-1:0]        mul_b_o,
  input  logic [2*N-1:0]      mul_result_i,
  input  logic                mul_overflow_i,
  output logic                busy_o
);
  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} slot_e;

  slot_e           state_q [NREQ];
  slot_e           state_d [NREQ];
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] eligible;
  logic            gnt_found;
  logic [IdxW-1:0] gnt_idx;
  logic            lo_found, hi_found;
  logic [IdxW-1:0] lo_idx, hi_idx;
  // Stage 0 pairs with the operand register; stage LAT lines up with mul_result_i.
  logic [LAT:0]    tag_vld_q;
  logic [IdxW-1:0] tag_idx_q [LAT+1];
  logic [N-1:0]    mul_a_q, mul_b_q;
  logic [2*N-1:0]  res_q [NREQ];
  logic [NREQ-1:0] ovf_q;
  logic            cap_vld;
  logic [IdxW-1:0] cap_idx;

  assign cap_vld  = tag_vld_q[LAT];
  assign cap_idx  = tag_idx_q[LAT];
  assign mul_en_o = 1'b1;
  assign mul_a_o  = mul_a_q;
  assign mul_b_o  = mul_b_q;
  assign bus.rsp_overflow = ovf_q;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] && (state_q[i] == StIdle);
    end
  end

  // Lowest eligible at/after rr_ptr wins; otherwise wrap to the lowest eligible overall.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(i);
      end
      if (eligible[i] && (IdxW'(i) >= rr_ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = IdxW'(i);
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    bus.req_ready = '0;
    if (gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        StIdle:  if (gnt_found && (gnt_idx == IdxW'(i))) state_d[i] = StBusy;
        StBusy:  if (cap_vld && (cap_idx == IdxW'(i)))   state_d[i] = StDone;
        StDone:  if (bus.rsp_ready[i])                   state_d[i] = StIdle;
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    busy_o         = 1'b0;
    bus.rsp_valid  = '0;
    bus.rsp_result = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.rsp_valid[i]                 = (state_q[i] == StDone);
      bus.rsp_result[i*2*N +: 2*N]     = res_q[i];
      busy_o                           = busy_o | (state_q[i] != StIdle);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      ovf_q     <= '0;
      for (int s = 0; s <= LAT; s++) tag_idx_q[s] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        state_q[i] <= StIdle;
        res_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q    <= {tag_vld_q[LAT-1:0], gnt_found};
      tag_idx_q[0] <= gnt_idx;
      for (int s = 1; s <= LAT; s++) tag_idx_q[s] <= tag_idx_q[s-1];
      if (gnt_found) begin
        mul_a_q <= bus.req_a[gnt_idx*N +: N];
        mul_b_q <= bus.req_b[gnt_idx*N +: N];
      end
      if (cap_vld) begin
        res_q[cap_idx] <= mul_result_i;
        ovf_q[cap_idx] <= mul_overflow_i;
      end
      for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
    end
  end
endmodule
